// File: rtl/shift_reg_ctrl.sv
// Sequencing controller for a BRAM-backed delay line of programmable length.
// Zero-fills the active region after reset/reconfiguration, then delays each
// accepted sample by exactly cur_len accepted samples (sample-counted delay).
module shift_reg_ctrl #(
  parameter int DATA_WIDTH  = 25,
  parameter int ADDR_WIDTH  = 9,
  parameter int DEFAULT_LEN = 512
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH:0]   cfg_len,
  input  logic                  cfg_load,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic [ADDR_WIDTH:0]   cur_len,
  output logic                  ram_en,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_di,
  input  logic [DATA_WIDTH-1:0] ram_do
);

  localparam int LW = ADDR_WIDTH + 1;
  localparam logic [LW-1:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [LW-1:0] DEF_LEN = LW'(DEFAULT_LEN);

  typedef enum logic {FLUSH, RUN} state_e;

  state_e                state_q, state_d;
  logic [LW-1:0]         len_q, len_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                  ovld_q, ovld_d;

  logic [LW-1:0] len_m1;
  logic [LW-1:0] cfg_clamped;
  logic          hs;

  assign len_m1    = len_q - LW'(1);
  assign in_ready  = rst_n && (state_q == RUN) && !cfg_load;
  assign hs        = in_valid && in_ready;
  assign out_valid = ovld_q;
  // RAM read data lines up with ovld_q: read happens on the handshake edge.
  assign out_data  = ram_do;
  assign busy      = !rst_n || (state_q == FLUSH);
  assign cur_len   = len_q;

  // Clamp requested length into 1..2**ADDR_WIDTH.
  always_comb begin
    cfg_clamped = cfg_len;
    if (cfg_len == '0)          cfg_clamped = LW'(1);
    else if (cfg_len > MAX_LEN) cfg_clamped = MAX_LEN;
  end

  // Next-state logic and RAM port control.
  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    addr_d   = addr_q;
    fcnt_d   = fcnt_q;
    ovld_d   = hs;
    ram_en   = 1'b0;
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_di   = in_data;
    case (state_q)
      FLUSH: begin
        ram_en   = 1'b1;
        ram_we   = 1'b1;
        ram_addr = fcnt_q;
        ram_di   = '0;
        if ({1'b0, fcnt_q} == len_m1) begin
          state_d = RUN;
          addr_d  = '0;
          fcnt_d  = '0;
        end else begin
          fcnt_d = fcnt_q + ADDR_WIDTH'(1);
        end
      end
      default: begin
        if (hs) begin
          // Same address: READ_FIRST returns the sample written cur_len
          // acceptances ago while the new one overwrites it.
          ram_en = 1'b1;
          ram_we = 1'b1;
          if ({1'b0, addr_q} == len_m1) addr_d = '0;
          else                          addr_d = addr_q + ADDR_WIDTH'(1);
        end
      end
    endcase
    // Reconfiguration wins in either state and restarts the zero-fill.
    if (cfg_load) begin
      len_d   = cfg_clamped;
      state_d = FLUSH;
      addr_d  = '0;
      fcnt_d  = '0;
    end
    if (!rst_n) begin
      ram_en = 1'b0;
      ram_we = 1'b0;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= FLUSH;
      len_q   <= DEF_LEN;
      addr_q  <= '0;
      fcnt_q  <= '0;
      ovld_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      addr_q  <= addr_d;
      fcnt_q  <= fcnt_d;
      ovld_q  <= ovld_d;
    end
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Scoreboard bench for shift_reg_ctrl: a queue-based delay-line model predicts
// each output when a sample is accepted; a negedge monitor pops and compares.
module tb_shift_reg_ctrl;
  localparam int DW = 25;
  localparam int AW = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW:0]   cfg_len = '0;
  logic          cfg_load = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, busy, ram_en, ram_we;
  logic [DW-1:0] out_data, ram_di, ram_do;
  logic [AW:0]   cur_len;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  shift_reg_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEFAULT_LEN(512)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_len(cfg_len), .cfg_load(cfg_load),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .busy(busy), .cur_len(cur_len),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_di(ram_di),
    .ram_do(ram_do)
  );

  // READ_FIRST simple-dual-port RAM, unregistered output (1-cycle read).
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (ram_en) begin
      ram_do <= mem[ram_addr];
      if (ram_we) mem[ram_addr] <= ram_di;
    end
  end

  int vectors = 0;
  int miscompares = 0;
  logic [DW-1:0] expq[$];
  logic [DW-1:0] dl[$];
  logic [DW-1:0] mon_e;
  bit run_exp = 1'b0;

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clampl(input int l);
    return (l == 0) ? 1 : ((l > 512) ? 512 : l);
  endfunction

  task automatic model_flush(input int l);
    dl.delete();
    repeat (l) dl.push_back('0);
    run_exp = 1'b0;
  endtask

  // Monitor: every out_valid must match the oldest predicted output.
  always @(negedge clk) begin
    if (out_valid) begin
      if (expq.size() == 0) check("out_unexpected", 1, 0);
      else begin
        mon_e = expq.pop_front();
        check("out_data", out_data, mon_e);
      end
    end
  end

  // One cycle of stimulus; prediction happens at acceptance time.
  task automatic cyc(input logic v, input logic [DW-1:0] d, input logic ld, input int l);
    @(posedge clk); #1;
    in_valid = v; in_data = d; cfg_load = ld; cfg_len = (AW+1)'(l);
    #1;
    if (ld) begin
      check("ready_on_load", in_ready, 0);
      model_flush(clampl(l));
    end else begin
      check("in_ready", in_ready, run_exp);
      if (v && in_ready) begin
        dl.push_back(d);
        expq.push_back(dl.pop_front());
      end
    end
  endtask

  // Called at posedge+1 of the first flush cycle. stop>0 checks only that
  // many flush cycles and returns while still flushing.
  task automatic flush_check(input int l, input int stop);
    int n = 0;
    int bad = 0;
    forever begin
      cfg_load = 1'b0;
      in_valid = 1'($urandom_range(0, 1));
      in_data  = DW'($urandom());
      #1;
      if (!busy) begin
        in_valid = 1'b0;
        break;
      end
      if (!(ram_en && ram_we && ram_di == '0 && ram_addr == n[AW-1:0] && !in_ready))
        bad++;
      n++;
      if (stop > 0 && n == stop) begin
        in_valid = 1'b0;
        check("flush_partial_bus", bad, 0);
        return;
      end
      if (n > 1100) begin
        check("flush_timeout", n, l);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    check("flush_bus", bad, 0);
    check("flush_len", n, l);
    check("cur_len", cur_len, l);
    check("ready_after_flush", in_ready, 1);
    run_exp = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 1);
    check("rst_cur_len", cur_len, 512);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    rst_n = 1'b1;
    model_flush(512);
    flush_check(512, 0);

    // Continuous stream at length 512
    for (int k = 1; k <= 600; k++) cyc(1'b1, DW'(k), 1'b0, 0);

    // Gapped input at length 4
    cyc(1'b0, '0, 1'b1, 4);
    @(posedge clk); #1;
    flush_check(4, 0);
    for (int k = 1; k <= 12; k++) begin
      cyc(1'b1, DW'(k), 1'b0, 0);
      cyc(1'b0, '0, 1'b0, 0);
    end

    // Mid-stream reconfiguration to 5 with in_valid held high
    for (int k = 0; k < 6; k++) cyc(1'b1, DW'($urandom()), 1'b0, 0);
    cyc(1'b1, DW'(777), 1'b1, 5);
    @(posedge clk); #1;
    flush_check(5, 0);
    for (int k = 0; k < 15; k++) cyc(1'b1, DW'($urandom()), 1'b0, 0);

    // Clamping: 0 -> 1, 600 -> 512
    cyc(1'b0, '0, 1'b1, 0);
    @(posedge clk); #1;
    flush_check(1, 0);
    for (int k = 0; k < 10; k++) cyc(1'b1, DW'($urandom()), 1'b0, 0);
    cyc(1'b0, '0, 1'b1, 600);
    @(posedge clk); #1;
    flush_check(512, 0);
    for (int k = 0; k < 20; k++) cyc(1'b1, DW'($urandom()), 1'b0, 0);

    // cfg_load during FLUSH restarts at the new length
    cyc(1'b0, '0, 1'b1, 8);
    @(posedge clk); #1;
    flush_check(8, 3);
    cyc(1'b0, '0, 1'b1, 6);
    @(posedge clk); #1;
    flush_check(6, 0);
    for (int k = 0; k < 20; k++) cyc(1'b1, DW'($urandom()), 1'b0, 0);

    // Reset during RUN
    @(posedge clk); #1;
    rst_n = 1'b0; in_valid = 1'b1; in_data = DW'(55);
    #1;
    check("rst_run_in_ready", in_ready, 0);
    check("rst_run_ram_en", ram_en, 0);
    @(posedge clk); #1;
    check("rst_run_out_valid", out_valid, 0);
    check("rst_run_busy", busy, 1);
    in_valid = 1'b0;
    rst_n = 1'b1;
    model_flush(512);
    flush_check(512, 0);

    // Randomized traffic with occasional reconfiguration
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        int nl;
        nl = $urandom_range(0, 600);
        cyc(1'($urandom_range(0, 1)), DW'($urandom()), 1'b1, nl);
        @(posedge clk); #1;
        flush_check(clampl(nl), 0);
      end else begin
        cyc(1'($urandom_range(0, 3) != 0), DW'($urandom()), 1'b0, 0);
      end
    end

    cyc(1'b0, '0, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", expq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/shift_reg_ctrl.md
# shift_reg_ctrl

Sequencing controller for the block-RAM delay line. It drives one single-clock simple-dual-port RAM (18Kb class, READ_FIRST, unregistered output) as a sample-counted delay line of runtime-programmable length. On reset and on reconfiguration it zero-fills the active region, then delays every accepted input sample by exactly `len` accepted samples behind a valid/ready handshake. It sits between an upstream sample producer and the downstream filter or datapath stage.

## Interface
- `DATA_WIDTH`, 25, sample width.
- `ADDR_WIDTH`, 9, RAM address width; maximum length is `2**ADDR_WIDTH`.
- `DEFAULT_LEN`, 512, length used after reset; must be in 1..`2**ADDR_WIDTH`.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset; synchronous, active-low.
- `cfg_len`  in  ADDR_WIDTH+1  requested delay length in samples.
- `cfg_load`  in  1  single-cycle pulse that latches `cfg_len` and starts a flush.
- `in_valid`  in  1  input sample valid.
- `in_data`  in  DATA_WIDTH  input sample.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `out_valid`  out  1  `out_data` is valid this cycle.
- `out_data`  out  DATA_WIDTH  delayed sample.
- `busy`  out  1  flush in progress.
- `cur_len`  out  ADDR_WIDTH+1  active length.
- `ram_en`  out  1  RAM port enable for read and write.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  ADDR_WIDTH  shared read and write address.
- `ram_di`  out  DATA_WIDTH  RAM write data.
- `ram_do`  in  DATA_WIDTH  RAM read data, one cycle after `ram_en`.

## Operation
- Two states: FLUSH and RUN.
- **Reset:** `rst_n` low forces state FLUSH, `cur_len`=`DEFAULT_LEN`, address counter and flush counter 0, `out_valid`=0.
  - While `rst_n` is low, `ram_en`=`ram_we`=0 and `in_ready`=0.
  - `busy`=1 from reset.
- **FLUSH:** each cycle asserts `ram_en`=`ram_we`=1, `ram_addr`=flush counter, `ram_di`=0.
  - The counter runs 0..`cur_len`-1.
  - After writing `cur_len`-1, the next state is RUN with address counter 0.
  - Flush lasts exactly `cur_len` cycles.
  - `in_ready`=0, `busy`=1.
- **RUN:** `in_ready` = (state==RUN) && !`cfg_load`, combinational.
  - On handshake: `ram_en`=`ram_we`=1, `ram_addr`=address counter, `ram_di`=`in_data`.
  - The old word at that address is read first.
  - The address counter then wraps from `cur_len`-1 to 0, otherwise increments.
  - With no handshake: `ram_en`=`ram_we`=0 and the counter holds.
- **Delay semantics:** the delay counts samples, not cycles.
  - The n-th accepted sample after a flush (n from 0) appears on the output of acceptance n+`cur_len`.
  - Acceptances 0..`cur_len`-1 output zeros.
- **cfg_load:** latches the clamped `cfg_len` into `cur_len`.
  - Clamp: 0 becomes 1; above `2**ADDR_WIDTH` becomes `2**ADDR_WIDTH`.
  - Enters FLUSH with both counters at 0.
  - Accepted in either state; during FLUSH it restarts the flush at the new length.
  - `cfg_load` has priority over a simultaneous `in_valid`, so no sample is accepted that cycle.
- A handshake accepted in the cycle before `cfg_load` still produces its `out_valid` pulse.
- No backpressure on the output: downstream must accept every `out_valid`.

## Timing
- Write/read latency is 1 cycle: handshake at cycle t gives `out_valid`=1 at t+1.
  - `out_valid` is a register.
  - `out_data` is `ram_do` passed through combinationally.
- `out_valid` is never asserted as a result of flush writes.
- Throughput: one sample per cycle in RUN.
- Reconfiguration cost: `cur_len` cycles of `in_ready`=0.
  - For example, `DEFAULT_LEN`=512 gives 512 cycles after `rst_n` rises.
- `cur_len` and `busy` update on the clock edge that follows `cfg_load`.
- Reset mid-operation discards all in-flight state. The `out_valid` due the next cycle is suppressed.

## Test plan
- **Reset flush:** release `rst_n`.
  - `busy`=1 and `ram_we`=1 with `ram_di`=0 for exactly 512 cycles, addresses 0..511.
  - Then `in_ready`=1 and `cur_len`=512.
- **Continuous stream:** apply `in_data`=k on every cycle at length 512.
  - The first 512 `out_data` values are 0.
  - Output then equals k-512, one cycle after acceptance.
- **Gapped input:** toggle `in_valid` 1/0 with `cfg_len`=4 and inputs 1,2,3,...
  - Outputs are 0,0,0,0,1,2,..., each appearing one cycle after its own acceptance.
- **Mid-stream reconfiguration:** apply `cfg_load` with `cfg_len`=5 while `in_valid`=1.
  - `in_ready`=0 that cycle, then 5 flush cycles.
  - The next 5 outputs are 0, then the delayed new samples.
- **Clamping:** `cfg_len`=0 gives `cur_len`=1 (output equals the previous sample). `cfg_len`=600 gives `cur_len`=512.
- **Edge events:** assert `rst_n` low during RUN, and `cfg_load` during FLUSH.
  - Reset gives no `out_valid`, followed by a 512-cycle flush.
  - `cfg_load` restarts the flush from address 0 at the new length.
